// File: rtl/pio_key_irq_servicer_pkg.sv
// Shared types and PIO register map for the key PIO IRQ servicer.
package pio_key_pkg;

    typedef enum logic [3:0] {
        INIT_MASK,
        IDLE,
        RD_CAP_A,
        RD_CAP_D,
        CLR_CAP,
        DEBOUNCE,
        RD_LVL_A,
        RD_LVL_D,
        CLR_BNC
    } state_t;

    localparam logic [1:0]  PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0]  PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0]  PIO_ADDR_EDGECAP = 2'd3;

    // Bit 0 set: enables the IRQ mask bit, or clears the edge-capture bit.
    localparam logic [31:0] PIO_WDATA_ONE    = 32'd1;

endpackage

// File: rtl/pio_key_irq_servicer_if.sv
// PIO Avalon-MM bus plus key-event valid/ready channel as seen by the servicer.
interface pio_key_irq_servicer_if #(
    parameter int COUNT_W = 16
);
    logic [1:0]         pio_address;
    logic               pio_chipselect;
    logic               pio_write_n;
    logic [31:0]        pio_writedata;
    logic [31:0]        pio_readdata;
    logic               pio_irq;
    logic               event_valid;
    logic               event_ready;
    logic [COUNT_W-1:0] event_count;

    modport master (
        output pio_address, pio_chipselect, pio_write_n, pio_writedata,
        output event_valid, event_count,
        input  pio_readdata, pio_irq, event_ready
    );

    modport slave (
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata,
        input  event_valid, event_count,
        output pio_readdata, pio_irq, event_ready
    );
endinterface

// File: rtl/pio_key_irq_servicer_timer.sv
// Loadable down-counter; done while the count sits at zero.
module key_debounce_timer #(
    parameter int TMR_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] load_value,
    output logic             done
);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/pio_key_irq_servicer.sv
// Key PIO IRQ servicer. States: INIT_MASK arm mask | IDLE wait irq | RD_CAP_A/D read edgecap | CLR_CAP clear+load
// timer | DEBOUNCE wait | RD_LVL_A/D read level, emit event | CLR_BNC flush bounce edges.
module pio_key_irq_servicer
    import pio_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TMR_W           = 20,
    parameter int COUNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    pio_key_irq_servicer_if.master bus,
    output logic                   overflow,
    output logic                   busy
);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DEBOUNCE_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_done;
    logic               rd_bit;
    logic               unused_rd;
    logic               valid_q;
    logic               overflow_q;
    logic [COUNT_W-1:0] count_q;

    assign rd_bit    = bus.pio_readdata[0];
    assign unused_rd = ^bus.pio_readdata[31:1];
    assign tmr_dec   = (state == DEBOUNCE);

    key_debounce_timer #(
        .TMR_W(TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .dec        (tmr_dec),
        .load_value (TMR_LOAD),
        .done       (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT_MASK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT_MASK: state_nxt = IDLE;
            IDLE:      if (enable && bus.pio_irq) state_nxt = RD_CAP_A;
            RD_CAP_A:  state_nxt = RD_CAP_D;
            RD_CAP_D:  state_nxt = rd_bit ? CLR_CAP : IDLE;
            CLR_CAP:   state_nxt = DEBOUNCE;
            DEBOUNCE:  if (tmr_done) state_nxt = RD_LVL_A;
            RD_LVL_A:  state_nxt = RD_LVL_D;
            RD_LVL_D:  state_nxt = CLR_BNC;
            CLR_BNC:   state_nxt = IDLE;
            default:   state_nxt = INIT_MASK;
        endcase
    end

    // Bus is held idle while reset is asserted so the mask write happens exactly once, after release.
    always_comb begin
        bus.pio_address    = PIO_ADDR_DATA;
        bus.pio_chipselect = 1'b0;
        bus.pio_write_n    = 1'b1;
        bus.pio_writedata  = '0;
        tmr_load           = 1'b0;
        if (!reset) begin
            case (state)
                INIT_MASK: begin
                    bus.pio_address    = PIO_ADDR_IRQMASK;
                    bus.pio_chipselect = 1'b1;
                    bus.pio_write_n    = 1'b0;
                    bus.pio_writedata  = PIO_WDATA_ONE;
                end
                RD_CAP_A: bus.pio_address = PIO_ADDR_EDGECAP;
                CLR_CAP: begin
                    bus.pio_address    = PIO_ADDR_EDGECAP;
                    bus.pio_chipselect = 1'b1;
                    bus.pio_write_n    = 1'b0;
                    bus.pio_writedata  = PIO_WDATA_ONE;
                    tmr_load           = 1'b1;
                end
                RD_LVL_A: bus.pio_address = PIO_ADDR_DATA;
                CLR_BNC: begin
                    bus.pio_address    = PIO_ADDR_EDGECAP;
                    bus.pio_chipselect = 1'b1;
                    bus.pio_write_n    = 1'b0;
                    bus.pio_writedata  = PIO_WDATA_ONE;
                end
                default: ;
            endcase
        end
    end

    // A confirmed press is dropped only if the previous event is still pending and not being taken this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if ((state == RD_LVL_D) && rd_bit) begin
            if (valid_q && !bus.event_ready) begin
                overflow_q <= 1'b1;
            end else begin
                valid_q <= 1'b1;
                count_q <= count_q + 1'b1;
            end
        end else if (bus.event_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.event_valid = valid_q;
    assign bus.event_count = count_q;
    assign overflow        = overflow_q;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_pio_key_irq_servicer.sv
// Bench for pio_key_irq_servicer: PIO slave model, cycle-indexed bus monitor, press-level event model.
module tb_pio_key_irq_servicer;

    localparam int D   = 4;
    localparam int TW  = 4;
    localparam int CW  = 4;
    localparam int HN  = 8192;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b1;
    logic overflow;
    logic busy;

    pio_key_irq_servicer_if #(.COUNT_W(CW)) bus();

    pio_key_irq_servicer #(
        .DEBOUNCE_CYCLES (D),
        .TMR_W           (TW),
        .COUNT_W         (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // PIO slave model: data level, irq mask, edge capture; read data one cycle after address.
    logic pio_mask    = 1'b0;
    logic pio_edgecap = 1'b0;
    logic spur_pend   = 1'b0;
    logic key_lvl     = 1'b0;
    logic cap_set     = 1'b0;
    logic spur_set    = 1'b0;
    logic pio_wr;

    assign pio_wr      = bus.pio_chipselect && !bus.pio_write_n;
    assign bus.pio_irq = (pio_edgecap & pio_mask) | spur_pend;

    always @(posedge clk) begin
        spur_pend <= spur_set;
        bus.pio_readdata <= {31'd0, (bus.pio_address == 2'd0) ? key_lvl :
                                    (bus.pio_address == 2'd2) ? pio_mask :
                                    (bus.pio_address == 2'd3) ? pio_edgecap : 1'b0};
        if (reset) begin
            pio_mask    <= 1'b0;
            pio_edgecap <= 1'b0;
        end else begin
            if (pio_wr && bus.pio_address == 2'd2) pio_mask <= bus.pio_writedata[0];
            if (pio_wr && bus.pio_address == 2'd3 && bus.pio_writedata[0]) pio_edgecap <= 1'b0;
            if (cap_set) pio_edgecap <= 1'b1;
        end
    end

    logic        wr_v    [HN];
    logic [1:0]  wr_a    [HN];
    logic [31:0] wr_d    [HN];
    logic        busy_at [HN];
    logic        val_at  [HN];

    always @(negedge clk) begin
        if (cyc < HN) begin
            wr_v[cyc]    <= pio_wr;
            wr_a[cyc]    <= bus.pio_address;
            wr_d[cyc]    <= bus.pio_writedata;
            busy_at[cyc] <= busy;
            val_at[cyc]  <= bus.event_valid;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int m_count = 0;
    bit m_valid = 1'b0;
    bit m_ovf   = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input int s, input int e, output int nwr, output int lb, output int rise,
                        output int w0c, output int w0a, output int w0d,
                        output int w1c, output int w1a, output int w1d);
        nwr = 0; lb = -1; rise = -1;
        w0c = -1; w0a = -1; w0d = -1; w1c = -1; w1a = -1; w1d = -1;
        for (int i = s; i < e; i++) begin
            if (wr_v[i] === 1'b1) begin
                if (nwr == 0) begin
                    w0c = i; w0a = int'(wr_a[i]); w0d = int'(wr_d[i]);
                end else if (nwr == 1) begin
                    w1c = i; w1a = int'(wr_a[i]); w1d = int'(wr_d[i]);
                end
                nwr++;
            end
            if (busy_at[i] === 1'b1) lb = i;
            if (rise < 0 && val_at[i] === 1'b1 && val_at[i-1] !== 1'b1) rise = i;
        end
    endtask

    // Runs the rest of one service window from IDLE cycle t and checks it against the press rules.
    task automatic finish_seq(input int s, input int t, input bit spur, input bit lvl, input bit rdy,
                              input bit late, input bit drop_en, input bit prior);
        int nwr, lb, rise, w0c, w0a, w0d, w1c, w1a, w1d;
        bit acc;
        while (cyc < t + D + 9) begin
            bus.event_ready = late ? (cyc == t + 5 + D) : rdy;
            if (drop_en && cyc == t + 5) enable = 1'b0;
            next_cycle();
        end
        bus.event_ready = 1'b0;
        scan(s, cyc, nwr, lb, rise, w0c, w0a, w0d, w1c, w1a, w1d);

        acc = !spur && lvl && !(prior && !(late ? 1'b1 : rdy));
        if (!spur && lvl && !acc) m_ovf = 1'b1;
        if (acc) m_count = (m_count + 1) % (1 << CW);
        m_valid = acc ? (late ? 1'b1 : !rdy) : (prior && !rdy && !late);

        chk("write_count", nwr, spur ? 0 : 2);
        if (!spur && nwr >= 1) begin
            chk("clr_cap_cycle", w0c, t + 3);
            chk("clr_cap_addr", w0a, 3);
            chk("clr_cap_data", w0d, 1);
        end
        if (!spur && nwr >= 2) begin
            chk("clr_bnc_cycle", w1c, t + 6 + D);
            chk("clr_bnc_addr", w1a, 3);
            chk("clr_bnc_data", w1d, 1);
        end
        chk("event_rise_cycle", rise, (acc && !(prior && late)) ? t + 6 + D : -1);
        chk("last_busy_cycle", lb, spur ? t + 2 : t + 6 + D);
        chk("event_valid", bus.event_valid, m_valid);
        chk("event_count", int'(bus.event_count), m_count);
        chk("overflow", overflow, m_ovf);
        chk("idle_busy", busy, 0);
    endtask

    task automatic run_seq(input bit spur, input bit lvl, input bit rdy, input bit late, input bit drop_en);
        int s;
        bit prior;
        s = cyc;
        prior = m_valid;
        if (spur) spur_set = 1'b1;
        else      cap_set  = 1'b1;
        key_lvl = lvl;
        bus.event_ready = late ? 1'b0 : rdy;
        next_cycle();
        cap_set  = 1'b0;
        spur_set = 1'b0;
        finish_seq(s, s + 1, spur, lvl, rdy, late, drop_en, prior);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int s, t, nwr, lb, rise, w0c, w0a, w0d, w1c, w1a, w1d;
        bus.event_ready = 1'b0;

        repeat (3) next_cycle();
        chk("rst_chipselect", bus.pio_chipselect, 0);
        chk("rst_write_n", bus.pio_write_n, 1);
        chk("rst_address", bus.pio_address, 0);
        chk("rst_writedata", bus.pio_writedata, 0);
        chk("rst_event_valid", bus.event_valid, 0);
        chk("rst_event_count", int'(bus.event_count), 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 1);

        s = cyc;
        reset = 1'b0;
        @(negedge clk);
        chk("init_chipselect", bus.pio_chipselect, 1);
        chk("init_write_n", bus.pio_write_n, 0);
        chk("init_address", bus.pio_address, 2);
        chk("init_writedata", bus.pio_writedata, 1);
        next_cycle();
        chk("init_busy_after", busy, 0);
        chk("init_cs_after", bus.pio_chipselect, 0);
        repeat (3) next_cycle();
        scan(s, cyc, nwr, lb, rise, w0c, w0a, w0d, w1c, w1a, w1d);
        chk("init_write_count", nwr, 1);

        run_seq(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // clean press
        run_seq(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // level glitch
        run_seq(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);   // spurious irq

        run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // pending event
        run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // dropped press
        bus.event_ready = 1'b1;
        next_cycle();
        bus.event_ready = 1'b0;
        m_valid = 1'b0;
        chk("ready_pulse_valid", bus.event_valid, 0);
        chk("ready_pulse_overflow", overflow, 1);

        run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_seq(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);   // accept and consume in one cycle

        s = cyc;
        enable = 1'b0;
        cap_set = 1'b1;
        key_lvl = 1'b1;
        next_cycle();
        cap_set = 1'b0;
        repeat (6) next_cycle();
        scan(s, cyc, nwr, lb, rise, w0c, w0a, w0d, w1c, w1a, w1d);
        chk("disabled_writes", nwr, 0);
        chk("disabled_busy", lb, -1);
        chk("disabled_irq_pending", bus.pio_irq, 1);
        s = cyc;
        enable = 1'b1;
        finish_seq(s, s, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m_valid);

        run_seq(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);   // enable dropped in DEBOUNCE
        enable = 1'b1;

        for (int k = 0; k < 20 && m_count != (1 << CW) - 1; k++) begin
            run_seq(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        run_seq(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("count_wrap", int'(bus.event_count), 0);

        for (int k = 0; k < 14; k++) begin
            bit r_spur, r_lvl, r_rdy, r_late;
            r_spur = ($urandom_range(0, 3) == 0);
            r_lvl  = $urandom_range(0, 1) == 1;
            r_rdy  = $urandom_range(0, 1) == 1;
            r_late = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 3)) next_cycle();
            run_seq(r_spur, r_lvl, r_rdy, r_late, 1'b0);
        end

        run_seq(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // leave an event pending
        cap_set = 1'b1;
        key_lvl = 1'b1;
        bus.event_ready = 1'b0;
        next_cycle();
        cap_set = 1'b0;
        t = cyc;
        while (cyc < t + 5) next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_event_valid", bus.event_valid, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_chipselect", bus.pio_chipselect, 1);
        chk("mid_rst_address", bus.pio_address, 2);
        chk("mid_rst_writedata", bus.pio_writedata, 1);
        chk("mid_rst_event_count", int'(bus.event_count), 0);
        chk("mid_rst_overflow", overflow, 0);
        next_cycle();
        chk("mid_rst_idle", busy, 0);
        m_valid = 1'b0;
        m_count = 0;
        m_ovf   = 1'b0;

        run_seq(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);   // mask must be re-armed

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
